rope_relax_engine: RTL and testbench
====================================

# rope_relax_engine

Parametrised rope-segment relaxation engine. It holds `NODES` 2-D node positions and relaxes them against their neighbours over `ITERS` sequential Gauss–Seidel passes, started by a handshake. It replaces the free-running one-hot node scheduler with the following:
- one shared, time-multiplexed update datapath;
- optional head pinning and tail mouse-grab;
- a start/done frame protocol.

Instances chain left to right: `next_x`/`next_y` connect to the right neighbour's node 0, and `prev_x`/`prev_y` connect to the left neighbour's last node.

## Interface
Parameters:
- `NODES`, default 5: nodes held; legal range ≥ 2.
- `W`, default 32: coordinate width, signed two's complement.
- `ITERS`, default 4: relaxation passes per frame; legal range ≥ 1.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: frame request; accepted only in IDLE.
- `busy`, out, 1: high while a frame is in progress.
- `done`, out, 1: one-cycle pulse at frame end.
- `prev_x`, `prev_y`, in, W: left boundary position; sampled at start.
- `next_x`, `next_y`, in, W: right boundary position; sampled at start.
- `mouse_x`, `mouse_y`, in, W: grab target; sampled at start.
- `head_pinned`, in, 1: when 1, node 0 is never updated; sampled at start.
- `tail_grab`, in, 1: when 1, node NODES-1 is set to the mouse position; sampled at start.
- `init_valid`, in, 1: position write strobe; honoured in IDLE only.
- `init_idx`, in, $clog2(NODES): node to write.
- `init_x`, `init_y`, in, W: position value to write.
- `nodes_x`, `nodes_y`, out, NODES*W: registered positions; node i occupies bits [(i+1)*W-1 : i*W].

## Operation
- The FSM has three states:
  - IDLE. On `start`, latch the boundary, mouse and mode inputs, clear `idx` and `iter`, and go to RELAX.
  - RELAX. Each cycle, update node `idx`, then advance as follows:
    - `idx` increments each cycle.
    - When `idx` = NODES-1, `idx` wraps to 0 and `iter` increments.
    - When `idx` = NODES-1 and `iter` = ITERS-1, go to DONE.
  - DONE. Assert `done`, then go to IDLE.
- Update rule for node `idx`:
  - L is the latched prev if `idx` = 0, otherwise node `idx`-1 (already updated in the current pass).
  - R is the latched next if `idx` = NODES-1, otherwise node `idx`+1.
  - New value = (L + R) >>> 1, computed in W+1 signed bits and truncated to W. Rounding is floor, so -3 and 0 give -2. Overflow cannot occur.
  - X and Y are updated in the same cycle using the same rule.
- Overrides:
  - `idx` = 0 with `head_pinned` latched: the position is held unchanged.
  - `idx` = NODES-1 with `tail_grab` latched: the position is set to the latched mouse position.
  - If both apply with NODES = 2, each rule applies to its own node.
- Init writes:
  - Applied in IDLE only.
  - Writes with `init_idx` ≥ NODES are dropped.
  - Writes are ignored when `busy`.
- `start` while `busy` or in DONE is ignored and not queued.

## Timing
- Reset values: all node positions 0, `busy` 0, `done` 0, state IDLE, all latched values 0.
- Reset has priority over every other input. Reset asserted mid-frame aborts the frame; all positions are 0 at the next edge and no `done` pulse is produced.
- Cycle numbering for a frame whose `start` is accepted at edge k:
  - `busy` is high for cycles k+1 through k+NODES*ITERS+1, including the DONE cycle.
  - Node updates become visible on `nodes_*` one cycle after their RELAX cycle.
  - `done` is high in cycle k+NODES*ITERS+1, and the final positions are stable and valid in that cycle.
- `start` and `init_valid` together in IDLE: the write commits at the same edge the start is accepted, and the relaxation sees the written value.
- The earliest back-to-back start is the cycle after `done`.

## Structure
- Shared package `rope_pkg`:
  - state enum {IDLE, RELAX, DONE};
  - default coordinate width constant;
  - index-width helper.
- Sub-module `rope_relax_unit`: combinational. Takes L, R, the self position, the pin/grab flags and the mouse position, and produces the new position. The engine instantiates it twice, once for X and once for Y.
- Node storage: two W-bit register arrays with a single write port; the write port is muxed between init writes and relax updates.

## Test plan
- Reset: assert `reset` = 0 for 2 cycles → all `nodes_*` = 0, `busy` = 0, `done` = 0. Deassert reset and apply `start` → `done` arrives exactly 1 + NODES*ITERS cycles later.
- Single pass, NODES = 5, ITERS = 1:
  - Stimulus: init x = 0, 100, 200, 300, 400; prev_x = 0; next_x = 500; no pin or grab.
  - Required: final x = 50, 125, 212, 306, 403; `done` in cycle k+6.
- Pin and grab:
  - Stimulus: `head_pinned` = 1, `tail_grab` = 1, mouse = (777, -5).
  - Required: node 0 is unchanged; node 4 = (777, -5) after every pass.
- Arithmetic:
  - Neighbours -3 and 0 give -2.
  - Neighbours 0x7FFFFFFF and 0x7FFFFFFF give 0x7FFFFFFF.
- Protocol:
  - A `start` pulse mid-frame is ignored and the frame length is unchanged.
  - An init write while busy is dropped.
  - A write with `init_idx` = 7 when NODES = 5 is dropped.
- Reset mid-frame: assert reset at RELAX cycle 3 → all positions are 0 at the next edge, `busy` = 0, and no `done` pulse.

Source files
------------

// File: rtl/rope_pkg.sv
// Shared types and helpers for the rope relaxation engine.
package rope_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RELAX = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_W = 32;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rope_relax_unit.sv
// One axis of the node update: floor midpoint of the neighbours, with the
// head-pin and tail-grab overrides applied on top.
module rope_relax_unit
    import rope_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic signed [W-1:0] l_i,
    input  logic signed [W-1:0] r_i,
    input  logic signed [W-1:0] self_i,
    input  logic signed [W-1:0] mouse_i,
    input  logic                pin_i,
    input  logic                grab_i,
    output logic signed [W-1:0] new_o
);

    logic signed [W:0]   sum;
    logic signed [W-1:0] avg;

    // One guard bit keeps the sum exact; the arithmetic shift rounds toward -inf.
    assign sum = {l_i[W-1], l_i} + {r_i[W-1], r_i};
    assign avg = W'(sum >>> 1);

    always_comb begin
        new_o = avg;
        if (pin_i) begin
            new_o = self_i;
        end else if (grab_i) begin
            new_o = mouse_i;
        end
    end

endmodule

// File: rtl/rope_relax_engine.sv
// Rope segment relaxation engine: sequential Gauss-Seidel passes over NODES
// positions through one shared update datapath, framed by start/done.
//
// state | meaning
// IDLE  | accepts init writes and start; latches boundary/mouse/mode on start
// RELAX | updates node idx each cycle, ITERS passes of NODES nodes
// DONE  | one-cycle done pulse, final positions valid
module rope_relax_engine
    import rope_pkg::*;
#(
    parameter int NODES = 5,
    parameter int W     = DEFAULT_W,
    parameter int ITERS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic signed [W-1:0]        prev_x,
    input  logic signed [W-1:0]        prev_y,
    input  logic signed [W-1:0]        next_x,
    input  logic signed [W-1:0]        next_y,
    input  logic signed [W-1:0]        mouse_x,
    input  logic signed [W-1:0]        mouse_y,
    input  logic                       head_pinned,
    input  logic                       tail_grab,
    input  logic                       init_valid,
    input  logic [$clog2(NODES)-1:0]   init_idx,
    input  logic signed [W-1:0]        init_x,
    input  logic signed [W-1:0]        init_y,
    output logic [NODES*W-1:0]         nodes_x,
    output logic [NODES*W-1:0]         nodes_y
);

    localparam int IW = idx_w(NODES);
    localparam int TW = idx_w(ITERS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NODES - 1);
    localparam logic [TW-1:0] LAST_ITER = TW'(ITERS - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [TW-1:0]       iter_q, iter_d;
    logic                accept;

    logic signed [W-1:0] prev_x_q, prev_y_q, next_x_q, next_y_q;
    logic signed [W-1:0] mouse_x_q, mouse_y_q;
    logic                pin_q, grab_q;

    logic signed [W-1:0] nodes_x_q [NODES];
    logic signed [W-1:0] nodes_y_q [NODES];

    logic signed [W-1:0] l_x, l_y, r_x, r_y, self_x, self_y, new_x, new_y;
    logic                pin_now, grab_now;

    logic                wr_en;
    logic [IW-1:0]       wr_idx;
    logic signed [W-1:0] wr_x, wr_y;

    // Left neighbour has already been rewritten this pass; right one has not.
    always_comb begin
        l_x    = prev_x_q;
        l_y    = prev_y_q;
        r_x    = next_x_q;
        r_y    = next_y_q;
        self_x = nodes_x_q[0];
        self_y = nodes_y_q[0];
        for (int i = 0; i < NODES; i++) begin
            if (idx_q == IW'(i)) begin
                self_x = nodes_x_q[i];
                self_y = nodes_y_q[i];
            end
        end
        for (int i = 1; i < NODES; i++) begin
            if (idx_q == IW'(i)) begin
                l_x = nodes_x_q[i-1];
                l_y = nodes_y_q[i-1];
            end
        end
        for (int i = 0; i < NODES - 1; i++) begin
            if (idx_q == IW'(i)) begin
                r_x = nodes_x_q[i+1];
                r_y = nodes_y_q[i+1];
            end
        end
    end

    assign pin_now  = pin_q  && (idx_q == '0);
    assign grab_now = grab_q && (idx_q == LAST_IDX);

    rope_relax_unit #(.W(W)) u_relax_x (
        .l_i     (l_x),
        .r_i     (r_x),
        .self_i  (self_x),
        .mouse_i (mouse_x_q),
        .pin_i   (pin_now),
        .grab_i  (grab_now),
        .new_o   (new_x)
    );

    rope_relax_unit #(.W(W)) u_relax_y (
        .l_i     (l_y),
        .r_i     (r_y),
        .self_i  (self_y),
        .mouse_i (mouse_y_q),
        .pin_i   (pin_now),
        .grab_i  (grab_now),
        .new_o   (new_y)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        iter_d  = iter_q;
        accept  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        wr_x    = new_x;
        wr_y    = new_y;
        case (state_q)
            IDLE: begin
                if (init_valid && (init_idx <= LAST_IDX)) begin
                    wr_en  = 1'b1;
                    wr_idx = init_idx;
                    wr_x   = init_x;
                    wr_y   = init_y;
                end
                if (start) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    iter_d  = '0;
                    state_d = RELAX;
                end
            end
            RELAX: begin
                wr_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    iter_d = iter_q + 1'b1;
                    if (iter_q == LAST_ITER) begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            iter_q    <= '0;
            prev_x_q  <= '0;
            prev_y_q  <= '0;
            next_x_q  <= '0;
            next_y_q  <= '0;
            mouse_x_q <= '0;
            mouse_y_q <= '0;
            pin_q     <= 1'b0;
            grab_q    <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
                nodes_x_q[i] <= '0;
                nodes_y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            iter_q  <= iter_d;
            if (accept) begin
                prev_x_q  <= prev_x;
                prev_y_q  <= prev_y;
                next_x_q  <= next_x;
                next_y_q  <= next_y;
                mouse_x_q <= mouse_x;
                mouse_y_q <= mouse_y;
                pin_q     <= head_pinned;
                grab_q    <= tail_grab;
            end
            if (wr_en) begin
                nodes_x_q[wr_idx] <= wr_x;
                nodes_y_q[wr_idx] <= wr_y;
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    for (genvar g = 0; g < NODES; g++) begin : g_out
        assign nodes_x[g*W +: W] = nodes_x_q[g];
        assign nodes_y[g*W +: W] = nodes_y_q[g];
    end

endmodule

// File: tb/tb_rope_relax_engine.sv
// Bench for rope_relax_engine: a single-pass and a three-pass instance share
// stimulus; frame results are scoreboarded and checked when done pulses.
module tb_rope_relax_engine;

    localparam int N = 5;
    localparam int W = 32;

    typedef logic [N-1:0][W-1:0] arr_t;
    typedef struct packed {
        arr_t       ix, iy;
        logic [W-1:0] px, py, nx, ny, mx, my;
        logic       pin, grab, poke;
        arr_t       ex1;
    } vec_t;
    typedef struct packed {
        arr_t x, y;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset, start, head_pinned, tail_grab, init_valid;
    logic [2:0]          init_idx;
    logic signed [W-1:0] prev_x, prev_y, next_x, next_y, mouse_x, mouse_y, init_x, init_y;
    logic                busy1, done1, busy3, done3;
    logic [N*W-1:0]      nodes_x1, nodes_y1, nodes_x3, nodes_y3;

    rope_relax_engine #(.NODES(N), .W(W), .ITERS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
        .prev_x(prev_x), .prev_y(prev_y), .next_x(next_x), .next_y(next_y),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .head_pinned(head_pinned),
        .tail_grab(tail_grab), .init_valid(init_valid), .init_idx(init_idx),
        .init_x(init_x), .init_y(init_y), .nodes_x(nodes_x1), .nodes_y(nodes_y1)
    );

    rope_relax_engine #(.NODES(N), .W(W), .ITERS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .busy(busy3), .done(done3),
        .prev_x(prev_x), .prev_y(prev_y), .next_x(next_x), .next_y(next_y),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .head_pinned(head_pinned),
        .tail_grab(tail_grab), .init_valid(init_valid), .init_idx(init_idx),
        .init_x(init_x), .init_y(init_y), .nodes_x(nodes_x3), .nodes_y(nodes_y3)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q1[$];
    exp_t q3[$];
    arr_t last_x1, last_x3;
    vec_t tbl[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic arr_t mk(input int a0, input int a1, input int a2, input int a3, input int a4);
        arr_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4;
        return r;
    endfunction

    function automatic vec_t vec(input arr_t ix, input arr_t iy, input int px, input int py,
                                 input int nx, input int ny, input int mx, input int my,
                                 input logic pin, input logic grab, input logic poke, input arr_t ex1);
        vec_t v;
        v.ix = ix; v.iy = iy; v.px = px; v.py = py; v.nx = nx; v.ny = ny;
        v.mx = mx; v.my = my; v.pin = pin; v.grab = grab; v.poke = poke; v.ex1 = ex1;
        return v;
    endfunction

    // Reference relaxation: exact 64-bit sums, floor halving, then truncate.
    function automatic arr_t model(input arr_t init, input logic [W-1:0] pv, input logic [W-1:0] nv,
                                   input logic [W-1:0] ms, input logic pin, input logic grab, input int iters);
        arr_t   n;
        longint l, r;
        n = init;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < N; i++) begin
                if (i == 0 && pin) begin
                    n[i] = n[i];
                end else if (i == N - 1 && grab) begin
                    n[i] = ms;
                end else begin
                    if (i == 0) l = longint'($signed(pv));
                    else        l = longint'($signed(n[i-1]));
                    if (i == N - 1) r = longint'($signed(nv));
                    else            r = longint'($signed(n[i+1]));
                    n[i] = W'((l + r) >>> 1);
                end
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                chk_i("done1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("dut1_x", nodes_x1, e.x);
                chk("dut1_y", nodes_y1, e.y);
                chk_i("dut1_done_cycle", cyc, e.due);
                chk_i("dut1_busy_at_done", int'(busy1), 1);
            end
        end
        if (done3) begin
            if (q3.size() == 0) begin
                chk_i("done3_unexpected", 1, 0);
            end else begin
                e = q3.pop_front();
                chk("dut3_x", nodes_x3, e.x);
                chk("dut3_y", nodes_y3, e.y);
                chk_i("dut3_done_cycle", cyc, e.due);
            end
        end
    end

    task automatic wait_frames();
        for (int t = 0; t < 40 && (q1.size() + q3.size()) != 0; t++) @(negedge clk);
        chk_i("frame_complete_pending", q1.size() + q3.size(), 0);
        q1.delete();
        q3.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int   k;
        exp_t e1, e3;
        for (int i = 0; i < N - 1; i++) begin
            @(negedge clk);
            init_valid = 1'b1; init_idx = 3'(i); init_x = v.ix[i]; init_y = v.iy[i];
        end
        @(negedge clk);
        init_idx = 3'(N - 1); init_x = v.ix[N-1]; init_y = v.iy[N-1];
        prev_x = v.px; prev_y = v.py; next_x = v.nx; next_y = v.ny;
        mouse_x = v.mx; mouse_y = v.my; head_pinned = v.pin; tail_grab = v.grab;
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        e1.x = v.ex1;
        e1.y = model(v.iy, v.py, v.ny, v.my, v.pin, v.grab, 1);
        e1.due = k + N;
        e3.x = model(v.ix, v.px, v.nx, v.mx, v.pin, v.grab, 3);
        e3.y = model(v.iy, v.py, v.ny, v.my, v.pin, v.grab, 3);
        e3.due = k + 3 * N;
        q1.push_back(e1);
        q3.push_back(e3);
        last_x1 = e1.x;
        last_x3 = e3.x;
        @(negedge clk);
        start = 1'b0; init_valid = 1'b0;
        // Changing the live inputs mid-frame must not disturb latched values.
        prev_x = 32'sd99999; next_x = -32'sd99999; mouse_x = 32'sd1; head_pinned = ~v.pin;
        if (v.poke) begin
            @(negedge clk);
            @(negedge clk);
            start = 1'b1; init_valid = 1'b1; init_idx = 3'd2; init_x = 32'sd12345; init_y = -32'sd1;
            @(negedge clk);
            start = 1'b0; init_valid = 1'b0;
        end
        wait_frames();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; head_pinned = 1'b0; tail_grab = 1'b0; init_valid = 1'b0;
        init_idx = '0; init_x = '0; init_y = '0; prev_x = '0; prev_y = '0;
        next_x = '0; next_y = '0; mouse_x = '0; mouse_y = '0;

        tbl[0] = vec(mk(0, 100, 200, 300, 400), mk(10, 20, 30, 40, 50), 0, 0, 500, -8, 0, 0,
                     1'b0, 1'b0, 1'b0, mk(50, 125, 212, 306, 403));
        tbl[1] = vec(mk(1000, 0, 0, 0, 0), mk(-7, 3, 3, 3, 3), -64, 9, 64, 9, 777, -5,
                     1'b1, 1'b1, 1'b0, mk(1000, 500, 250, 125, 777));
        tbl[2] = vec(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), -3, -3, 0, 0, 0, 0,
                     1'b0, 1'b0, 1'b0, mk(-2, -1, -1, -1, -1));
        tbl[3] = vec(mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                     mk($signed(32'h80000000), $signed(32'h80000000), $signed(32'h80000000),
                        $signed(32'h80000000), $signed(32'h80000000)),
                     32'h7FFFFFFF, $signed(32'h80000000), 32'h7FFFFFFF, $signed(32'h80000000), 0, 0,
                     1'b0, 1'b0, 1'b0,
                     mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF));
        tbl[4] = vec(mk(0, 100, 200, 300, 400), mk(10, 20, 30, 40, 50), 0, 0, 500, -8, 0, 0,
                     1'b0, 1'b0, 1'b1, mk(50, 125, 212, 306, 403));
        tbl[5] = vec(mk(8, 8, 8, 8, 8), mk(-1, -2, -3, -4, -5), 0, 6, 0, -6, 55, 55,
                     1'b1, 1'b0, 1'b0, mk(8, 8, 8, 8, 4));
        tbl[6] = vec(mk(0, 0, 0, 0, 0), mk(1, 2, 3, 4, 5), 40, 0, 0, 0, -100, 31,
                     1'b0, 1'b1, 1'b0, mk(20, 10, 5, 2, -100));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_nodes_x1", nodes_x1, '0);
        chk("reset_nodes_y3", nodes_y3, '0);
        chk_i("reset_busy", int'(busy1) + int'(busy3), 0);
        chk_i("reset_done", int'(done1) + int'(done3), 0);

        // First frame straight out of reset on all-zero nodes: timing check.
        begin
            exp_t e;
            int   k;
            reset = 1'b1;
            start = 1'b1;
            @(posedge clk);
            #1;
            k = cyc;
            e.x = '0; e.y = '0; e.due = k + N;
            q1.push_back(e);
            e.due = k + 3 * N;
            q3.push_back(e);
            @(negedge clk);
            start = 1'b0;
            chk_i("busy_after_start", int'(busy1) + int'(busy3), 2);
            wait_frames();
        end

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Out-of-range init index must leave every node untouched.
        @(negedge clk);
        init_valid = 1'b1; init_idx = 3'd7; init_x = 32'sd4242; init_y = 32'sd4242;
        @(negedge clk);
        init_valid = 1'b0;
        @(negedge clk);
        chk("oob_write_x1", nodes_x1, last_x1);
        chk("oob_write_x3", nodes_x3, last_x3);

        // Reset during RELAX aborts the frame with no done pulse.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_x1", nodes_x1, '0);
        chk("midreset_x3", nodes_x3, '0);
        chk("midreset_y3", nodes_y3, '0);
        chk_i("midreset_busy", int'(busy1) + int'(busy3), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        chk_i("midreset_idle", int'(busy1) + int'(busy3), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
